// File: rtl/mm_bram_tiled_acc.sv
// Tiled BRAM matrix-multiply pass: out[r][c] = psum[r][c] + sum_k in[r][k]*W[k][c], one row per cycle.
// Define MM_BRAM_TILED_SAT_EN to saturate the psum addition instead of wrapping.
module mm_bram_tiled_acc #(
   parameter  int DATA_WIDTH     = 8,
   parameter  int ACC_WIDTH      = 32,
   parameter  int ROW_NUM        = 32,
   parameter  int COL_NUM        = 32,
   parameter  int LENGTH         = 32,
   localparam int ROW_ADDR_WIDTH = (ROW_NUM > 1) ? $clog2(ROW_NUM) : 1
) (
   input  logic                                   clk,
   input  logic                                   reset,
   input  logic                                   val_in,
   output logic                                   rdy_in,
   input  logic                                   first_tile,
   input  logic [COL_NUM-1:0]                     col_mask,
   input  logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]   weights,
   output logic [ROW_ADDR_WIDTH*LENGTH-1:0]       row_rdaddr,
   input  logic [DATA_WIDTH*LENGTH-1:0]           row_data_in,
   output logic [ROW_ADDR_WIDTH*COL_NUM-1:0]      psum_rdaddr,
   input  logic [ACC_WIDTH*COL_NUM-1:0]           psum_data_in,
   output logic [ACC_WIDTH*COL_NUM-1:0]           row_data_out,
   output logic [ROW_ADDR_WIDTH*COL_NUM-1:0]      row_wraddr,
   output logic [COL_NUM-1:0]                     row_wr_en,
   output logic                                   done
);

   localparam int PW = 2 * DATA_WIDTH;
   localparam int AW = ROW_ADDR_WIDTH;
   localparam logic [AW-1:0] LAST_ROW = AW'(ROW_NUM - 1);

   if (ACC_WIDTH < 2 * DATA_WIDTH + $clog2(LENGTH)) begin : g_bad_acc
      $error("mm_bram_tiled_acc: ACC_WIDTH too small for the dot product");
   end

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                                 r_state;
   logic                                   r_rdy;
   logic                                   r_first;
   logic [COL_NUM-1:0]                     r_mask;
   logic [DATA_WIDTH*LENGTH*COL_NUM-1:0]   r_w;
   logic [AW-1:0]                          r_ra;
   logic [AW-1:0]                          r_pa;
   logic [AW-1:0]                          r_wa;
   logic [COL_NUM-1:0]                     r_wen;
   logic                                   r_done;
   logic [3:1]                             r_vld_pipe;
   logic [AW-1:0]                          r_idx_pipe [3:1];
   logic [COL_NUM-1:0][ACC_WIDTH-1:0]      r_out;
   logic [COL_NUM-1:0][ACC_WIDTH-1:0]      w_sum;
   logic signed [PW-1:0]                   r_prod [COL_NUM][LENGTH];
   logic signed [ACC_WIDTH-1:0]            r_dot  [COL_NUM];
   logic signed [ACC_WIDTH-1:0]            w_dot  [COL_NUM];

   // Control, valid pipe and registered outputs; stage n of the pipe holds the row issued n cycles ago.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= IDLE;
         r_rdy      <= 1'b1;
         r_first    <= 1'b0;
         r_mask     <= '0;
         r_w        <= '0;
         r_ra       <= '0;
         r_pa       <= '0;
         r_wa       <= '0;
         r_wen      <= '0;
         r_done     <= 1'b0;
         r_vld_pipe <= '0;
         r_out      <= '0;
         for (int i = 1; i <= 3; i++) r_idx_pipe[i] <= '0;
      end else begin
         r_vld_pipe    <= {r_vld_pipe[2:1], r_state == ISSUE};
         r_idx_pipe[1] <= r_ra;
         r_idx_pipe[2] <= r_idx_pipe[1];
         r_idx_pipe[3] <= r_idx_pipe[2];
         if (r_vld_pipe[1]) r_pa <= r_idx_pipe[1];
         r_wen  <= r_vld_pipe[3] ? r_mask : '0;
         r_done <= r_vld_pipe[3] && (r_idx_pipe[3] == LAST_ROW);
         if (r_vld_pipe[3]) begin
            r_wa  <= r_idx_pipe[3];
            r_out <= w_sum;
         end
         case (r_state)
            IDLE: if (val_in) begin
               r_w     <= weights;
               r_mask  <= col_mask;
               r_first <= first_tile;
               r_ra    <= '0;
               r_rdy   <= 1'b0;
               r_state <= ISSUE;
            end
            ISSUE: begin
               if (r_ra == LAST_ROW) r_state <= DRAIN;
               else                  r_ra    <= r_ra + 1'b1;
            end
            DRAIN: if (r_done) begin
               r_state <= IDLE;
               r_rdy   <= 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Datapath registers need no reset: nothing downstream looks at them without a valid bit.
   always_ff @(posedge clk) begin
      for (int c = 0; c < COL_NUM; c++) begin
         for (int k = 0; k < LENGTH; k++)
            r_prod[c][k] <= PW'($signed(row_data_in[k*DATA_WIDTH +: DATA_WIDTH]))
                          * PW'($signed(r_w[(c*LENGTH+k)*DATA_WIDTH +: DATA_WIDTH]));
         r_dot[c] <= w_dot[c];
      end
   end

   always_comb begin
      for (int c = 0; c < COL_NUM; c++) begin
         w_dot[c] = '0;
         for (int k = 0; k < LENGTH; k++)
            w_dot[c] = w_dot[c] + ACC_WIDTH'(r_prod[c][k]);
      end
   end

   for (genvar c = 0; c < COL_NUM; c++) begin : g_col
      logic [ACC_WIDTH-1:0] w_psum;
      assign w_psum = r_first ? '0 : psum_data_in[c*ACC_WIDTH +: ACC_WIDTH];
`ifdef MM_BRAM_TILED_SAT_EN
      // One guard bit: differing top bits mean the add left the representable range.
      logic [ACC_WIDTH:0] w_ext;
      assign w_ext    = {r_dot[c][ACC_WIDTH-1], r_dot[c]} + {w_psum[ACC_WIDTH-1], w_psum};
      assign w_sum[c] = (w_ext[ACC_WIDTH] == w_ext[ACC_WIDTH-1]) ? w_ext[ACC_WIDTH-1:0]
                      : {w_ext[ACC_WIDTH], {(ACC_WIDTH-1){~w_ext[ACC_WIDTH]}}};
`else
      assign w_sum[c] = r_dot[c] + w_psum;
`endif
   end

   assign rdy_in       = r_rdy;
   assign row_rdaddr   = {LENGTH{r_ra}};
   assign psum_rdaddr  = {COL_NUM{r_pa}};
   assign row_wraddr   = {COL_NUM{r_wa}};
   assign row_wr_en    = r_wen;
   assign done         = r_done;
   assign row_data_out = r_out;

endmodule
